// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter.
//   ADR_WIDTH / DAT_WIDTH / WB_SEL_WIDTH : bus widths of the shared slave port
//   arb_state_t                          : arbiter FSM encoding
//   idx_width()                          : bits needed to index a master
package wb_arbiter_pkg;

  localparam int ADR_WIDTH    = 48;
  localparam int DAT_WIDTH    = 64;
  localparam int WB_SEL_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE  = 2'd0,
    ARB_STATE_BUSY  = 2'd1,
    ARB_STATE_ABORT = 2'd2
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches i_req starting at i_last+1 and wrapping modulo N; the first set
// bit wins, so the previously served index has the lowest priority.
//   i_req   : request vector
//   i_last  : index served last
//   o_pick  : one-hot winner
//   o_idx   : binary index of winner
//   o_valid : at least one request present
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_pick,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Walk from the farthest candidate to the nearest so the nearest set bit
  // overwrites any earlier hit; avoids a break in the loop.
  always_comb begin
    int k;
    k       = 0;
    o_pick  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int off = N; off >= 1; off--) begin
      k = (int'(i_last) + off) % N;
      if (i_req[k]) begin
        o_pick    = '0;
        o_pick[k] = 1'b1;
        o_idx     = IW'(k);
        o_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter with bus watchdog.
// The grant is held for the full CYC of the granted master; a slave that
// never answers is turned into an ERR after TIMEOUT stalled STB cycles.
//   clk_i, rst_i (sync, active low)
//   m_*_i     : packed per-master request buses (master k at slice k)
//   m_dat_o   : slave read data, broadcast
//   m_ack_o / m_err_o : response routed to granted master only
//   s_*_o / s_*_i     : shared slave port
//   grant_o   : one-hot current grant
//
// state | meaning
// IDLE  | no grant; arbitrate among m_cyc_i
// BUSY  | granted master drives the slave port
// ABORT | watchdog expired; slave port quiet until master drops CYC
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0]  m_dat_i,
  output logic [DAT_WIDTH-1:0]              m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [WB_SEL_WIDTH-1:0]           s_sel_o,
  output logic [ADR_WIDTH-1:0]              s_adr_o,
  output logic [DAT_WIDTH-1:0]              s_dat_o,
  input  logic [DAT_WIDTH-1:0]              s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IW   = idx_width(NUM_MASTERS);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t             r_state, w_next_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_gidx;
  logic [IW-1:0]          r_last;
  logic [WD_W-1:0]        r_wd_cnt;
  logic                   r_abort_first;

  logic [NUM_MASTERS-1:0] w_pick;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_valid;

  logic [WB_SEL_WIDTH-1:0] w_sel_arr [NUM_MASTERS];
  logic [ADR_WIDTH-1:0]    w_adr_arr [NUM_MASTERS];
  logic [DAT_WIDTH-1:0]    w_dat_arr [NUM_MASTERS];

  logic w_cyc_g, w_stb_g, w_we_g;
  logic w_wd_stall, w_wd_expire;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign w_sel_arr[k] = m_sel_i[k*WB_SEL_WIDTH +: WB_SEL_WIDTH];
    assign w_adr_arr[k] = m_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
    assign w_dat_arr[k] = m_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
  end

  rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_rr_pick (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_cyc_g = m_cyc_i[r_gidx];
  assign w_stb_g = m_stb_i[r_gidx];
  assign w_we_g  = m_we_i[r_gidx];

  // A stalled cycle is STB waiting with no response of either kind.
  assign w_wd_stall  = w_stb_g && !s_ack_i && !s_err_i;
  assign w_wd_expire = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST);

  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;

  always_comb begin
    w_next_state = r_state;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_sel_o      = '0;
    s_adr_o      = '0;
    s_dat_o      = '0;
    m_ack_o      = '0;
    m_err_o      = '0;
    case (r_state)
      ARB_STATE_IDLE: begin
        if (w_pick_valid) w_next_state = ARB_STATE_BUSY;
      end
      ARB_STATE_BUSY: begin
        s_cyc_o = w_cyc_g;
        s_stb_o = w_stb_g;
        s_we_o  = w_we_g;
        s_sel_o = w_sel_arr[r_gidx];
        s_adr_o = w_adr_arr[r_gidx];
        s_dat_o = w_dat_arr[r_gidx];
        m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
        m_err_o = r_grant & {NUM_MASTERS{s_err_i}};
        // Master release wins over expiry; an answering slave never expires.
        if (!w_cyc_g)                        w_next_state = ARB_STATE_IDLE;
        else if (w_wd_stall && w_wd_expire) w_next_state = ARB_STATE_ABORT;
      end
      ARB_STATE_ABORT: begin
        m_err_o = r_grant & {NUM_MASTERS{r_abort_first}};
        if (!w_cyc_g) w_next_state = ARB_STATE_IDLE;
      end
      default: w_next_state = ARB_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state       <= ARB_STATE_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_last        <= IW'(NUM_MASTERS - 1);
      r_wd_cnt      <= '0;
      r_abort_first <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_abort_first <= (r_state == ARB_STATE_BUSY) && (w_next_state == ARB_STATE_ABORT);

      if (r_state == ARB_STATE_IDLE && w_pick_valid) begin
        r_grant <= w_pick;
        r_gidx  <= w_pick_idx;
        r_last  <= w_pick_idx;
      end else if (w_next_state == ARB_STATE_IDLE) begin
        r_grant <= '0;
      end

      if (TIMEOUT != 0 && r_state == ARB_STATE_BUSY &&
          w_next_state == ARB_STATE_BUSY && w_wd_stall)
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      else
        r_wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter (3 masters, TIMEOUT=4).
// A transaction-level reference model tracks the bus owner, the number of
// cycles STB has waited without answer, and abort status.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N = 3;
  localparam int T = 4;
  localparam int NCYC = 4000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                        rst_i;
  logic [N-1:0]                m_cyc_i, m_stb_i, m_we_i;
  logic [N*WB_SEL_WIDTH-1:0]   m_sel_i;
  logic [N*ADR_WIDTH-1:0]      m_adr_i;
  logic [N*DAT_WIDTH-1:0]      m_dat_i;
  logic [DAT_WIDTH-1:0]        m_dat_o;
  logic [N-1:0]                m_ack_o, m_err_o, grant_o;
  logic                        s_cyc_o, s_stb_o, s_we_o;
  logic [WB_SEL_WIDTH-1:0]     s_sel_o;
  logic [ADR_WIDTH-1:0]        s_adr_o;
  logic [DAT_WIDTH-1:0]        s_dat_o;
  logic [DAT_WIDTH-1:0]        s_dat_i;
  logic                        s_ack_i, s_err_i;

  wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // per-master stimulus fields
  logic [WB_SEL_WIDTH-1:0] sel_a [N];
  logic [ADR_WIDTH-1:0]    adr_a [N];
  logic [DAT_WIDTH-1:0]    dat_a [N];
  logic [N-1:0]            got_resp;

  // reference model state
  int owner;     // -1 when nobody holds the bus
  int last;
  int waitc;     // cycles STB has been left unanswered
  bit aborted;
  bit err_now;

  // expected outputs
  logic                    e_cyc, e_stb, e_we;
  logic [WB_SEL_WIDTH-1:0] e_sel;
  logic [ADR_WIDTH-1:0]    e_adr;
  logic [DAT_WIDTH-1:0]    e_dat;
  logic [N-1:0]            e_ack, e_err, e_grant;

  task automatic model_reset();
    owner = -1; last = N - 1; waitc = 0; aborted = 0; err_now = 0;
  endtask

  task automatic model_outputs();
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = '0; e_adr = '0; e_dat = '0;
    e_ack = '0; e_err = '0; e_grant = '0;
    if (owner >= 0) begin
      e_grant = N'(1) << owner;
      if (aborted) begin
        e_err[owner] = err_now;
      end else begin
        e_cyc = m_cyc_i[owner];
        e_stb = m_stb_i[owner];
        e_we  = m_we_i[owner];
        e_sel = sel_a[owner];
        e_adr = adr_a[owner];
        e_dat = dat_a[owner];
        e_ack[owner] = s_ack_i;
        e_err[owner] = s_err_i;
      end
    end
  endtask

  task automatic model_step();
    int pick;
    if (!rst_i) begin
      model_reset();
    end else if (owner < 0) begin
      pick = -1;
      for (int off = 1; off <= N; off++)
        if (pick < 0 && m_cyc_i[(last + off) % N]) pick = (last + off) % N;
      if (pick >= 0) begin
        owner = pick; last = pick; waitc = 0;
      end
    end else if (aborted) begin
      err_now = 0;
      if (!m_cyc_i[owner]) begin owner = -1; aborted = 0; end
    end else if (!m_cyc_i[owner]) begin
      owner = -1; waitc = 0;
    end else if (m_stb_i[owner] && !s_ack_i && !s_err_i) begin
      waitc++;
      if (waitc == T) begin aborted = 1; err_now = 1; waitc = 0; end
    end else begin
      waitc = 0;
    end
  endtask

  task automatic new_fields(input int k);
    adr_a[k] = {16'($urandom), $urandom};
    dat_a[k] = {$urandom, $urandom};
    sel_a[k] = 8'($urandom);
    m_we_i[k] = 1'($urandom);
  endtask

  task automatic pack();
    for (int k = 0; k < N; k++) begin
      m_sel_i[k*WB_SEL_WIDTH +: WB_SEL_WIDTH] = sel_a[k];
      m_adr_i[k*ADR_WIDTH +: ADR_WIDTH]       = adr_a[k];
      m_dat_i[k*DAT_WIDTH +: DAT_WIDTH]       = dat_a[k];
    end
  endtask

  initial begin
    bit slow;
    rst_i = 0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    for (int k = 0; k < N; k++) begin sel_a[k] = '0; adr_a[k] = '0; dat_a[k] = '0; end
    pack();
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
    got_resp = '0;
    slow = 0;
    model_reset();
    repeat (2) @(posedge clk_i);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk_i);
      rst_i = (cyc % 900 == 450) ? 1'b0 : 1'b1;
      if (cyc % 250 == 0) slow = ($urandom_range(0, 3) == 0);

      for (int k = 0; k < N; k++) begin
        if (!m_cyc_i[k]) begin
          if ($urandom_range(0, 3) == 0) begin m_cyc_i[k] = 1; new_fields(k); end
        end else if (got_resp[k]) begin
          if ($urandom_range(0, 1) == 0) m_cyc_i[k] = 0;
          else new_fields(k);
        end else if ($urandom_range(0, 39) == 0) begin
          m_cyc_i[k] = 0;
        end
        m_stb_i[k] = m_cyc_i[k] && ($urandom_range(0, 7) != 0);
      end
      pack();

      model_outputs();
      s_dat_i = {$urandom, $urandom};
      if (e_stb && !slow) begin
        s_ack_i = ($urandom_range(0, 2) == 0);
        s_err_i = ($urandom_range(0, 11) == 0);
      end else begin
        s_ack_i = 0; s_err_i = 0;
      end
      model_outputs();

      #1;
      chk("s_cyc",  64'(s_cyc_o), 64'(e_cyc));
      chk("s_stb",  64'(s_stb_o), 64'(e_stb));
      chk("s_we",   64'(s_we_o),  64'(e_we));
      chk("s_sel",  64'(s_sel_o), 64'(e_sel));
      chk("s_adr",  64'(s_adr_o), 64'(e_adr));
      chk("s_dat",  64'(s_dat_o), 64'(e_dat));
      chk("m_ack",  64'(m_ack_o), 64'(e_ack));
      chk("m_err",  64'(m_err_o), 64'(e_err));
      chk("grant",  64'(grant_o), 64'(e_grant));
      chk("m_dat",  64'(m_dat_o), 64'(s_dat_i));

      got_resp = e_ack | e_err;
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin Wishbone B4 (classic) arbiter.
- Shares one slave-side bus (ROM/RAM/peripheral decoder) between NUM_MASTERS masters: the cpu instruction/data port, plus a DMA or debug master.
- Holds the grant for the whole CYC of the granted master.
- Includes a bus watchdog that converts a missing slave ACK into ERR, so a master waiting on ACK/ERR never hangs.

Parameters:
- NUM_MASTERS, 2: number of requesting masters (2..8).
- TIMEOUT, 255: max cycles STB may wait for ACK/ERR before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_sel_i  in  NUM_MASTERS*8  per-master SEL, master k at [8k+7:8k].
- m_adr_i  in  NUM_MASTERS*`ADR_WIDTH  per-master address, same packing.
- m_dat_i  in  NUM_MASTERS*`DAT_WIDTH  per-master write data.
- m_dat_o  out  `DAT_WIDTH  slave read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  ACK, routed only to the granted master.
- m_err_o  out  NUM_MASTERS  ERR, routed to the granted master (slave ERR or timeout).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side control.
- s_sel_o  out  8  slave SEL.
- s_adr_o  out  `ADR_WIDTH  slave address.
- s_dat_o  out  `DAT_WIDTH  slave write data.
- s_dat_i  in  `DAT_WIDTH  slave read data.
- s_ack_i, s_err_i  in  1 each  slave response.
- grant_o  out  NUM_MASTERS  one-hot current grant (debug/monitor).

Behaviour:
- Reset (rst_i==0 at clock edge):
  - state=IDLE, grant=0, last=NUM_MASTERS-1, wd_cnt=0.
  - All s_* control outputs, m_ack_o, m_err_o and grant_o read 0.
  - Reset mid-transfer drops s_cyc_o/s_stb_o at the next edge; no ACK is forwarded.
- States:
  - IDLE: no grant. If any m_cyc_i is set, pick the first set bit searching from last+1 upward, wrapping modulo NUM_MASTERS. Register grant and last, go to BUSY. Arbitration latency is 1 cycle: s_cyc_o rises the cycle after the request is seen.
  - BUSY: s_cyc/stb/we/sel/adr/dat are combinational muxes of the granted master's inputs. m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i, combinational; other bits are 0. When m_cyc_i[g]==0, go to IDLE and clear grant.
  - ABORT: entered on watchdog expiry. s_cyc_o=s_stb_o=0; m_err_o[g]=1 for exactly the first ABORT cycle. Stay until m_cyc_i[g]==0, then go to IDLE.
- Fairness: after releasing, the arbiter always spends one IDLE cycle. The just-served master has lowest priority in the next arbitration. A master holding CYC continuously starves others; this is by design, since CYC denotes a locked sequence.
- Watchdog:
  - In BUSY, wd_cnt increments each cycle with s_stb_o=1 and s_ack_i=s_err_i=0.
  - It clears on ACK, ERR, STB low, or a state change.
  - When wd_cnt==TIMEOUT-1 and still no response, the next state is ABORT.
  - wd_cnt width is $clog2(TIMEOUT+1); it never wraps.
- Simultaneous events:
  - Slave ACK in the same cycle the watchdog expires: ACK wins, no ABORT.
  - Master drops CYC in the same cycle as an ACK: ACK is still passed through, then IDLE.
  - Requests arriving while BUSY are ignored until IDLE.
  - s_ack_i and s_err_i both set: both are forwarded; masters treat ERR as dominant.
- m_dat_o = s_dat_i at all times; pure wire, no register.

Decomposition:
- wishbone.v (shared include) supplies `ADR_WIDTH, `DAT_WIDTH, and a new `WB_SEL_WIDTH (8).
- Arbiter state encodings are `ARB_STATE_IDLE/BUSY/ABORT, local to the file.
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, last index.
  - Outputs: one-hot pick, index, valid.
  - Unit-testable on its own.

Test Plan:
- Single request: m_cyc_i=01 at cycle 0, slave ACKs on its 2nd STB cycle, adr 0x800000000000 → s_cyc_o high from cycle 1, m_ack_o=01 for one cycle, grant_o=00 one cycle after CYC drops.
- Contention: both CYC asserted together from reset → master 0 served first. Each master drops CYC after its ACK, then re-asserts CYC one cycle later. Result: grant order 0,1,0,1 with one IDLE cycle between grants.
- Isolation: master 1 requests while master 0 is in BUSY with a 5-cycle-latency slave → s_adr_o stays at master 0's address and m_ack_o[1]=0 throughout; master 1 is granted only after master 0 drops CYC.
- Timeout: TIMEOUT=4, slave never ACKs → m_err_o[g]=1 for one cycle after STB has been high 4 cycles, s_cyc_o=0 from that cycle, state IDLE once the master drops CYC.
- Race: ACK arrives exactly on the expiry cycle → m_ack_o asserted, m_err_o stays 0.
- Reset mid-operation: rst_i=0 during BUSY → next cycle s_cyc_o=0 and grant_o=0. After release, arbitration restarts at master 0.
